// File: rtl/mult_seq.sv
// mult_seq: multi-cycle shift-add multiplier producing a registered
// 2*WIDTH-bit product split into MultHI/MultLO plus an overflow flag.
// Operands are captured on Start in IDLE and iterated one bit per clock.
// The result is registered when the DONE state is left, so Done rises
// WIDTH+1 cycles after the Start edge and the result holds until the next operation.
// Optional feature macro: MULT_MULTU_EN adds the Unsigned port (MULT/MULTU select).
// Without it every operation is signed.
module mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] MultSrc1,
    input  logic [WIDTH-1:0] MultSrc2,
`ifdef MULT_MULTU_EN
    input  logic             Unsigned,
`endif
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] MultHI,
    output logic [WIDTH-1:0] MultLO,
    output logic             Over
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0]   W_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] P_ONE  = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]      CNT_INIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]      CNT_ZERO = {CW{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Two's-complement magnitude; the most negative value maps to 2^(W-1),
    // which still fits as an unsigned WIDTH-bit number.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        if (v[WIDTH-1]) begin
            r = (~v) + W_ONE;
        end else begin
            r = v;
        end
        return r;
    endfunction

    state_t             state_r;
    logic [CW-1:0]      cnt_r;
    logic [2*WIDTH:0]   acc_r;
    logic [WIDTH-1:0]   mcand_r;
    logic               neg_r;
    logic               uns_r;

    logic               uns_in_s;
    logic [WIDTH-1:0]   cap_mcand_s;
    logic [WIDTH-1:0]   cap_mplier_s;
    logic               cap_neg_s;
    logic [WIDTH:0]     sum_s;
    logic [2*WIDTH:0]   acc_add_s;
    logic [2*WIDTH:0]   acc_step_s;
    logic [2*WIDTH-1:0] prod_s;
    logic               over_s;

`ifdef MULT_MULTU_EN
    assign uns_in_s = Unsigned;
`else
    assign uns_in_s = 1'b0;
`endif

    // Operand conditioning at capture: magnitudes and result sign for MULT, raw for MULTU.
    always_comb begin
        cap_mcand_s  = MultSrc1;
        cap_mplier_s = MultSrc2;
        cap_neg_s    = 1'b0;
        if (uns_in_s) begin
            cap_mcand_s  = MultSrc1;
            cap_mplier_s = MultSrc2;
            cap_neg_s    = 1'b0;
        end else begin
            cap_mcand_s  = abs_val(MultSrc1);
            cap_mplier_s = abs_val(MultSrc2);
            cap_neg_s    = MultSrc1[WIDTH-1] ^ MultSrc2[WIDTH-1];
        end
    end

    // One shift-add iteration: conditional add into the upper W+1 bits, then logical shift right.
    always_comb begin
        sum_s      = acc_r[2*WIDTH:WIDTH] + {1'b0, mcand_r};
        acc_add_s  = acc_r;
        if (acc_r[0]) begin
            acc_add_s = {sum_s, acc_r[WIDTH-1:0]};
        end else begin
            acc_add_s = acc_r;
        end
        acc_step_s = {1'b0, acc_add_s[2*WIDTH:1]};
    end

    // Final signed product and overflow decision from the finished accumulator.
    always_comb begin
        prod_s = acc_r[2*WIDTH-1:0];
        over_s = 1'b0;
        if (neg_r) begin
            prod_s = (~acc_r[2*WIDTH-1:0]) + P_ONE;
        end else begin
            prod_s = acc_r[2*WIDTH-1:0];
        end
        if (uns_r) begin
            over_s = (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
        end else begin
            over_s = (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}});
        end
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
            cnt_r   <= CNT_ZERO;
            acc_r   <= {(2*WIDTH+1){1'b0}};
            mcand_r <= {WIDTH{1'b0}};
            neg_r   <= 1'b0;
            uns_r   <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            MultHI  <= {WIDTH{1'b0}};
            MultLO  <= {WIDTH{1'b0}};
            Over    <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        mcand_r <= cap_mcand_s;
                        acc_r   <= {1'b0, {WIDTH{1'b0}}, cap_mplier_s};
                        neg_r   <= cap_neg_s;
                        uns_r   <= uns_in_s;
                        cnt_r   <= CNT_INIT;
                        Busy    <= 1'b1;
                        state_r <= S_RUN;
                    end else begin
                        Busy    <= 1'b0;
                        state_r <= S_IDLE;
                    end
                end
                S_RUN: begin
                    Done  <= 1'b0;
                    Busy  <= 1'b1;
                    acc_r <= acc_step_s;
                    cnt_r <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ZERO) begin
                        state_r <= S_DONE;
                    end else begin
                        state_r <= S_RUN;
                    end
                end
                S_DONE: begin
                    MultHI  <= prod_s[2*WIDTH-1:WIDTH];
                    MultLO  <= prod_s[WIDTH-1:0];
                    Over    <= over_s;
                    Done    <= 1'b1;
                    Busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    Done    <= 1'b0;
                    Busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq (WIDTH=32): directed vector table,
// randomized operations against a plain-arithmetic reference model, and
// hand-written sequences for Start re-pulsing and reset during RUN.
// The Unsigned port and MULTU vectors are used only when MULT_MULTU_EN is defined.
module tb_mult_seq;

    localparam int W = 32;
`ifdef MULT_MULTU_EN
    localparam bit MULTU = 1'b1;
`else
    localparam bit MULTU = 1'b0;
`endif

    logic         clk;
    logic         reset_n;
    logic         Start;
    logic [W-1:0] MultSrc1;
    logic [W-1:0] MultSrc2;
`ifdef MULT_MULTU_EN
    logic         Unsigned;
`endif
    logic         Busy;
    logic         Done;
    logic [W-1:0] MultHI;
    logic [W-1:0] MultLO;
    logic         Over;

    int n_checks = 0;
    int n_errors = 0;

    mult_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .Start    (Start),
        .MultSrc1 (MultSrc1),
        .MultSrc2 (MultSrc2),
`ifdef MULT_MULTU_EN
        .Unsigned (Unsigned),
`endif
        .Busy     (Busy),
        .Done     (Done),
        .MultHI   (MultHI),
        .MultLO   (MultLO),
        .Over     (Over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         u;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         ov;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: full-precision product with plain arithmetic; bit 64 = overflow.
    function automatic logic [64:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic u);
        logic [63:0]        up;
        logic signed [63:0] sp;
        logic               ov;
        if (u) begin
            up = {32'd0, a} * {32'd0, b};
            ov = (up > 64'h0000_0000_FFFF_FFFF);
        end else begin
            sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            up = sp;
            ov = (sp > 64'sd2147483647) || (sp < -64'sd2147483648);
        end
        return {ov, up};
    endfunction

    task automatic set_uns(input logic u);
`ifdef MULT_MULTU_EN
        Unsigned = u;
`else
        if (u) $display("note: unsigned request ignored in signed-only build");
`endif
    endtask

    // Issue one operation (called #1 after a posedge, DUT in IDLE); returns result and latency.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic u,
                          output logic [W-1:0] hi, output logic [W-1:0] lo,
                          output logic ov, output int lat);
        MultSrc1 = a;
        MultSrc2 = b;
        set_uns(u);
        Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        chk("busy_after_start", {63'd0, Busy}, 64'd1);
        MultSrc1 = $urandom;
        MultSrc2 = $urandom;
        set_uns(MULTU ? ~u : 1'b0);
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (Done) begin
                lat = n;
                break;
            end
        end
        if (lat < 0) chk("done_timeout", 64'd0, 64'd1);
        hi = MultHI;
        lo = MultLO;
        ov = Over;
        @(posedge clk); #1;
        chk("done_one_cycle", {63'd0, Done}, 64'd0);
        chk("busy_idle", {63'd0, Busy}, 64'd0);
        chk("hold_hi", {32'd0, MultHI}, {32'd0, hi});
    endtask

    vec_t         vecs[10];
    logic [W-1:0] hi, lo;
    logic         ov;
    int           lat;
    logic [64:0]  r;

    initial begin
        vecs[0] = '{32'h0000_0007, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[1] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 32'h0000_0000, 1'b1};
        vecs[2] = '{32'h0001_0000, 32'h0001_0000, 1'b0, 32'h0000_0001, 32'h0000_0000, 1'b1};
        vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h0000_0001, 1'b0};
        vecs[4] = '{32'h0000_0000, 32'h1234_5678, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[5] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 32'h3FFF_FFFF, 32'h0000_0001, 1'b1};
        vecs[6] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0};
        vecs[7] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h8000_0000, 1'b1};
        vecs[8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1};
        vecs[9] = '{32'h8000_0000, 32'h0000_0002, 1'b1, 32'h0000_0001, 32'h0000_0000, 1'b1};

        reset_n  = 1'b0;
        Start    = 1'b0;
        MultSrc1 = 32'd0;
        MultSrc2 = 32'd0;
        set_uns(1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hi", {32'd0, MultHI}, 64'd0);
        chk("rst_lo", {32'd0, MultLO}, 64'd0);
        chk("rst_over", {63'd0, Over}, 64'd0);
        chk("rst_busy", {63'd0, Busy}, 64'd0);
        chk("rst_done", {63'd0, Done}, 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors.
        for (int i = 0; i < 10; i++) begin
            if (!vecs[i].u || MULTU) begin
                run_op(vecs[i].a, vecs[i].b, vecs[i].u, hi, lo, ov, lat);
                chk($sformatf("vec%0d_hi", i), {32'd0, hi}, {32'd0, vecs[i].hi});
                chk($sformatf("vec%0d_lo", i), {32'd0, lo}, {32'd0, vecs[i].lo});
                chk($sformatf("vec%0d_over", i), {63'd0, ov}, {63'd0, vecs[i].ov});
                chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd33);
            end
        end

        // Randomized operations, biased toward corner operands.
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] a, b;
            logic         u;
            logic [W-1:0] pool[5];
            pool[0] = 32'h0000_0000;
            pool[1] = 32'h0000_0001;
            pool[2] = 32'hFFFF_FFFF;
            pool[3] = 32'h8000_0000;
            pool[4] = 32'h7FFF_FFFF;
            a = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : $urandom;
            if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(8, 30);
            u = MULTU ? 1'($urandom_range(0, 1)) : 1'b0;
            r = ref_mul(a, b, u);
            run_op(a, b, u, hi, lo, ov, lat);
            chk($sformatf("rnd%0d_prod a=%h b=%h u=%0d", i, a, b, u), {hi, lo}, r[63:0]);
            chk($sformatf("rnd%0d_over", i), {63'd0, ov}, {63'd0, r[64]});
        end

        // Start re-pulsed with new operands at edges 5 and 33 of a running operation.
        begin
            int dones;
            int first_lat;
            logic [W-1:0] shi, slo;
            logic         sov;
            dones = 0;
            first_lat = -1;
            shi = 32'd0;
            slo = 32'd0;
            sov = 1'b0;
            r = ref_mul(32'h0001_2345, 32'hFFFF_0003, 1'b0);
            MultSrc1 = 32'h0001_2345;
            MultSrc2 = 32'hFFFF_0003;
            set_uns(1'b0);
            Start = 1'b1;
            @(posedge clk); #1;
            Start = 1'b0;
            for (int n = 1; n <= 45; n++) begin
                MultSrc1 = $urandom;
                MultSrc2 = $urandom;
                Start = (n == 5 || n == 33);
                @(posedge clk); #1;
                Start = 1'b0;
                if (Done) begin
                    dones++;
                    if (first_lat < 0) begin
                        first_lat = n;
                        shi = MultHI;
                        slo = MultLO;
                        sov = Over;
                    end
                end
            end
            chk("repulse_done_count", 64'(dones), 64'd1);
            chk("repulse_latency", 64'(first_lat), 64'd33);
            chk("repulse_prod", {shi, slo}, r[63:0]);
            chk("repulse_over", {63'd0, sov}, {63'd0, r[64]});
            chk("repulse_idle_busy", {63'd0, Busy}, 64'd0);
        end

        // Reset during RUN: known nonzero result first, then abort at RUN cycle 10.
        run_op(32'h0000_0007, 32'hFFFF_FFFD, 1'b0, hi, lo, ov, lat);
        chk("pre_rst_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFEB);
        begin
            int dones;
            dones = 0;
            MultSrc1 = 32'h0000_0100;
            MultSrc2 = 32'h0000_0100;
            Start = 1'b1;
            @(posedge clk); #1;
            Start = 1'b0;
            repeat (10) @(posedge clk);
            #1;
            reset_n = 1'b0;
            #1;
            chk("midrst_hi", {32'd0, MultHI}, 64'd0);
            chk("midrst_lo", {32'd0, MultLO}, 64'd0);
            chk("midrst_over", {63'd0, Over}, 64'd0);
            chk("midrst_busy", {63'd0, Busy}, 64'd0);
            chk("midrst_done", {63'd0, Done}, 64'd0);
            #2;
            reset_n = 1'b1;
            @(posedge clk); #1;
            for (int n = 0; n < 40; n++) begin
                if (Done) dones++;
                @(posedge clk); #1;
            end
            chk("midrst_no_done", 64'(dones), 64'd0);
            chk("midrst_idle_busy", {63'd0, Busy}, 64'd0);
        end
        r = ref_mul(32'hFFFF_FFF0, 32'h0000_0123, 1'b0);
        run_op(32'hFFFF_FFF0, 32'h0000_0123, 1'b0, hi, lo, ov, lat);
        chk("post_rst_prod", {hi, lo}, r[63:0]);
        chk("post_rst_over", {63'd0, ov}, {63'd0, r[64]});
        chk("post_rst_latency", 64'(lat), 64'd33);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
